// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline constants for the stall/flush sequencer: FSM state encoding
// and the default SRAM latency.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int MEM_LAT_DEF = 4;
    localparam int CNT_W_DEF   = 8;
    localparam int PERF_W_DEF  = 32;

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones; async active-high reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Freeze/flush/bubble sequencer for the 5-stage pipeline, including the
// fixed-latency SRAM wait FSM. Optional perf counters: PIPE_STALL_PERF_CNT_EN.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int PERF_W  = PERF_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hazard,
    input  logic              branch_taken,
    input  logic              mem_req,
    output logic              freeze_pc,
    output logic              flush_if,
    output logic              bubble_id,
    output logic              freeze_all,
    output logic              sram_start,
    output logic              mem_done,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    state_e           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             mstall;

    // Memory-wait FSM: RUN launches the access, WAIT counts down, DONE releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_req) begin
                        wait_cnt <= CNT_W'(MEM_LAT - 1);
                        state    <= (MEM_LAT == 1) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - CNT_W'(1);
                    if (wait_cnt == CNT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_RUN;
                default: state <= ST_RUN;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path leaves a latch; the
    // outputs are also forced low while rst is asserted, because the state
    // register alone would let a Mealy sram_start leak out during reset.
    always_comb begin
        mstall     = 1'b0;
        freeze_all = 1'b0;
        sram_start = 1'b0;
        mem_done   = 1'b0;
        flush_if   = 1'b0;
        freeze_pc  = 1'b0;
        bubble_id  = 1'b0;
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    mstall     = mem_req;
                    sram_start = mem_req;
                end
                ST_WAIT: mstall   = 1'b1;
                ST_DONE: mem_done = 1'b1;
                default: mstall   = 1'b0;
            endcase
            freeze_all = mstall;
            // A taken branch squashes the hazarding ID instruction, so it wins.
            flush_if   = branch_taken & ~mstall;
            freeze_pc  = hazard & ~branch_taken & ~mstall;
            bubble_id  = hazard & ~branch_taken & ~mstall;
        end
    end

`ifdef PIPE_STALL_PERF_CNT_EN
    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (freeze_pc | freeze_all),
        .count (stall_cnt)
    );

    sat_counter #(.W(PERF_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (flush_if),
        .count (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
